// File: rtl/rv32i_pkg.sv
// Shared rv32i pipeline types used by the hazard controller: forwarding selects,
// hazard FSM states and the E/M/W shadow scoreboard record.
package rv32i_pkg;

   localparam int REG_AW = 5;

   typedef enum logic [1:0] {
      FWD_NONE = 2'b00,
      FWD_WB   = 2'b01,
      FWD_MEM  = 2'b10
   } fwd_sel_t;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MEM_WAIT = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              regwrite;
      logic              is_load;
      logic              is_mem;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
   } hz_rec_t;

   // A record is a hazard source only if it really writes a non-x0 register.
   function automatic logic hz_src(input hz_rec_t r);
      return r.valid && r.regwrite && (r.rd != '0);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
// Forwarding select for one E-stage source operand: the younger M-stage result
// wins over W, and a load still in M cannot forward (its data is not back yet).
import rv32i_pkg::*;

module hz_fwd_sel (
   input  logic [REG_AW-1:0] src,
   input  logic              m_src,
   input  logic [REG_AW-1:0] m_rd,
   input  logic              m_load,
   input  logic              w_src,
   input  logic [REG_AW-1:0] w_rd,
   output fwd_sel_t          sel
);

   always_comb begin
      sel = FWD_NONE;
      if (m_src && (m_rd == src) && !m_load)
         sel = FWD_MEM;
      else if (w_src && (w_rd == src))
         sel = FWD_WB;
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard / stall / flush controller for the 5-stage rv32i pipeline: shadow
// scoreboard of E/M/W, load-use detection, forwarding selects and dmem freeze.
import rv32i_pkg::*;

module pipeline_hazard_ctrl #(
   parameter  int ADW      = 5,
   parameter  int MAX_WAIT = 16,
   localparam int CW       = $clog2(MAX_WAIT + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           instr_validD,
   input  logic [ADW-1:0] addr_1D,
   input  logic [ADW-1:0] addr_2D,
   input  logic           use_rs1D,
   input  logic           use_rs2D,
   input  logic [4:0]     RdD,
   input  logic           regwriteD,
   input  logic           resultsrcD,
   input  logic           memwriteD,
   input  logic           redirectE,
   input  logic           dmem_ready,
   output logic           stallF,
   output logic           stallD,
   output logic           stallE,
   output logic           stallM,
   output logic           flushD,
   output logic           flushE,
   output logic           flushW,
   output fwd_sel_t       fwdAE,
   output fwd_sel_t       fwdBE,
   output hz_state_t      hz_state,
   output logic           mem_timeout
);

   hz_rec_t   rec_d, rec_e, rec_m, rec_w;
   hz_state_t state, state_nxt;
   logic [CW-1:0] wait_cnt, wait_nxt;
   logic      m_access, freeze, load_use;
   logic      unused_rec_w;

   assign hz_state     = state;
   assign unused_rec_w = ^{rec_w.is_load, rec_w.is_mem, rec_w.rs1, rec_w.rs2};

   always_comb begin
      rec_d          = '0;
      rec_d.valid    = 1'b1;
      rec_d.rd       = RdD;
      rec_d.regwrite = regwriteD;
      rec_d.is_load  = resultsrcD;
      rec_d.is_mem   = resultsrcD | memwriteD;
      rec_d.rs1      = addr_1D;
      rec_d.rs2      = addr_2D;
   end

   assign m_access = rec_m.valid && rec_m.is_mem;
   assign load_use = instr_validD && rec_e.is_load && hz_src(rec_e) &&
                     ((use_rs1D && (addr_1D == rec_e.rd)) ||
                      (use_rs2D && (addr_2D == rec_e.rd)));

   // The M access is frozen on every cycle it is not ready, including the RUN
   // cycle that discovers it; otherwise the access would slide into W unfinished.
   always_comb begin
      state_nxt = state;
      freeze    = 1'b0;
      wait_nxt  = '0;
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      flushD    = 1'b0;
      flushE    = 1'b0;
      flushW    = 1'b0;
      case (state)
         HZ_RUN: begin
            if (m_access && !dmem_ready) begin
               state_nxt = HZ_MEM_WAIT;
               freeze    = 1'b1;
            end
         end
         HZ_MEM_WAIT: begin
            if (dmem_ready) state_nxt = HZ_RUN;
            else            freeze    = 1'b1;
         end
         default: state_nxt = HZ_RUN;
      endcase
      if (freeze)
         wait_nxt = (wait_cnt == CW'(MAX_WAIT)) ? wait_cnt : wait_cnt + 1'b1;
      if (rst_n) begin
         if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
         end else if (redirectE) begin
            flushD = 1'b1;
            flushE = 1'b1;
         end else if (load_use) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HZ_RUN;
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
         if (wait_nxt == CW'(MAX_WAIT)) mem_timeout <= 1'b1;
      end
   end

   // While frozen, E and M hold; W takes the bubble the M/W register receives.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_e <= '0;
         rec_m <= '0;
         rec_w <= '0;
      end else if (freeze) begin
         rec_w <= '0;
      end else begin
         rec_e <= (flushE || !instr_validD) ? '0 : rec_d;
         rec_m <= rec_e;
         rec_w <= rec_m;
      end
   end

   hz_fwd_sel u_fwd_a (
      .src    (rec_e.rs1),
      .m_src  (hz_src(rec_m)),
      .m_rd   (rec_m.rd),
      .m_load (rec_m.is_load),
      .w_src  (hz_src(rec_w)),
      .w_rd   (rec_w.rd),
      .sel    (fwdAE)
   );

   hz_fwd_sel u_fwd_b (
      .src    (rec_e.rs2),
      .m_src  (hz_src(rec_m)),
      .m_rd   (rec_m.rd),
      .m_load (rec_m.is_load),
      .w_src  (hz_src(rec_w)),
      .w_rd   (rec_w.rd),
      .sel    (fwdBE)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus random bench for pipeline_hazard_ctrl against a model that
// tracks the instructions sitting in E/M/W and applies the hazard rules.
import rv32i_pkg::*;

module tb_pipeline_hazard_ctrl;

   localparam int MAX_W = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       instr_validD, use_rs1D, use_rs2D, regwriteD, resultsrcD, memwriteD;
   logic [4:0] addr_1D, addr_2D, RdD;
   logic       redirectE, dmem_ready;
   logic       stallF, stallD, stallE, stallM, flushD, flushE, flushW, mem_timeout;
   fwd_sel_t   fwdAE, fwdBE;
   hz_state_t  hz_state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.ADW(5), .MAX_WAIT(MAX_W)) dut (
      .clk(clk), .rst_n(rst_n), .instr_validD(instr_validD),
      .addr_1D(addr_1D), .addr_2D(addr_2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
      .RdD(RdD), .regwriteD(regwriteD), .resultsrcD(resultsrcD), .memwriteD(memwriteD),
      .redirectE(redirectE), .dmem_ready(dmem_ready),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .flushD(flushD), .flushE(flushE), .flushW(flushW),
      .fwdAE(fwdAE), .fwdBE(fwdBE), .hz_state(hz_state), .mem_timeout(mem_timeout)
   );

   // Model: the instruction occupying each of E, M, W.
   typedef struct {
      bit v;
      int rd;
      bit wr, ld, mem;
      int rs1, rs2;
   } minst_t;

   minst_t slot_e, slot_m, slot_w;
   bit     waiting;     // previous cycle was a memory wait cycle
   int     waited;
   bit     timed_out;
   bit     x_frz, x_flushE;

   function automatic minst_t empty_slot();
      minst_t s;
      s.v = 0; s.rd = 0; s.wr = 0; s.ld = 0; s.mem = 0; s.rs1 = 0; s.rs2 = 0;
      return s;
   endfunction

   function automatic bit writer(input minst_t s);
      return s.v && s.wr && (s.rd != 0);
   endfunction

   function automatic int ref_fwd(input int src);
      if (writer(slot_m) && slot_m.rd == src && !slot_m.ld) return 2;
      if (writer(slot_w) && slot_w.rd == src) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      slot_e = empty_slot(); slot_m = empty_slot(); slot_w = empty_slot();
      waiting = 0; waited = 0; timed_out = 0;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_d(input bit v, input int rd, input int a1, input int a2,
                        input bit u1, input bit u2, input bit wr, input bit ld, input bit st);
      instr_validD = v; RdD = 5'(rd); addr_1D = 5'(a1); addr_2D = 5'(a2);
      use_rs1D = u1; use_rs2D = u2; regwriteD = wr; resultsrcD = ld; memwriteD = st;
   endtask

   task automatic set_nop();
      set_d(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Settle combinational outputs after the falling-edge drive and compare.
   task automatic settle();
      bit lu, redir, st_fd, fe;
      #1;
      if (!rst_n) model_reset();
      x_frz = 0; lu = 0; redir = 0;
      if (rst_n) begin
         x_frz = slot_m.v && slot_m.mem && !dmem_ready;
         lu = instr_validD && slot_e.v && slot_e.ld && writer(slot_e) &&
              ((use_rs1D && int'(addr_1D) == slot_e.rd) || (use_rs2D && int'(addr_2D) == slot_e.rd));
         redir = redirectE && !x_frz;
      end
      st_fd    = x_frz || (lu && !redir);
      fe       = !x_frz && (redir || lu);
      x_flushE = fe;
      chk("stallF", 8'(stallF), 8'(st_fd));
      chk("stallD", 8'(stallD), 8'(st_fd));
      chk("stallE", 8'(stallE), 8'(x_frz));
      chk("stallM", 8'(stallM), 8'(x_frz));
      chk("flushD", 8'(flushD), 8'(redir));
      chk("flushE", 8'(flushE), 8'(fe));
      chk("flushW", 8'(flushW), 8'(x_frz));
      chk("fwdAE", 8'(fwdAE), 8'(ref_fwd(slot_e.rs1)));
      chk("fwdBE", 8'(fwdBE), 8'(ref_fwd(slot_e.rs2)));
      chk("hz_state", 8'(hz_state), 8'(waiting));
      chk("mem_timeout", 8'(mem_timeout), 8'(timed_out));
   endtask

   task automatic tick();
      minst_t d;
      @(posedge clk);
      if (!rst_n) model_reset();
      else if (x_frz) begin
         slot_w = empty_slot();
         if (waited < MAX_W) waited++;
         if (waited == MAX_W) timed_out = 1;
         waiting = 1;
      end else begin
         d.v = 1; d.rd = int'(RdD); d.wr = regwriteD; d.ld = resultsrcD;
         d.mem = resultsrcD | memwriteD; d.rs1 = int'(addr_1D); d.rs2 = int'(addr_2D);
         slot_w = slot_m;
         slot_m = slot_e;
         slot_e = (x_flushE || !instr_validD) ? empty_slot() : d;
         waited = 0;
         waiting = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      rst_n = 0; dmem_ready = 1; redirectE = 0; set_nop();
      repeat (2) @(negedge clk);
      settle();
      chk("rst_state", 8'(hz_state), 8'(HZ_RUN));
      tick();
      rst_n = 1;

      // add x5,x1,x2 ; add x6,x5,x3 ; add x7,x5,x5
      set_d(1, 5, 1, 2, 1, 1, 1, 0, 0); settle(); tick();
      set_d(1, 6, 5, 3, 1, 1, 1, 0, 0); settle(); tick();
      set_d(1, 7, 5, 5, 1, 1, 1, 0, 0); settle();
      chk("ex_fwdA_mem", 8'(fwdAE), 8'(FWD_MEM));
      chk("ex_fwdB_none", 8'(fwdBE), 8'(FWD_NONE));
      tick();
      set_nop(); settle();
      chk("ex_fwdA_wb", 8'(fwdAE), 8'(FWD_WB));
      chk("ex_fwdB_wb", 8'(fwdBE), 8'(FWD_WB));
      tick();

      // lw x5,0(x1) ; add x7,x5,x1 -> one stall bubble then W forward
      set_d(1, 5, 1, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_d(1, 7, 5, 1, 1, 1, 1, 0, 0); settle();
      chk("lu_stallD", 8'(stallD), 8'd1);
      chk("lu_flushE", 8'(flushE), 8'd1);
      tick();
      settle();
      chk("lu_once", 8'(stallD), 8'd0);
      tick();
      set_nop(); settle();
      chk("lu_fwdA_wb", 8'(fwdAE), 8'(FWD_WB));
      tick();

      // lw x0 ; add x7,x0,x0 -> never a hazard
      set_d(1, 0, 1, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_d(1, 7, 0, 0, 1, 1, 1, 0, 0); settle();
      chk("x0_nostall", 8'(stallD), 8'd0);
      tick();
      set_nop(); settle();
      chk("x0_fwdA", 8'(fwdAE), 8'(FWD_NONE));
      chk("x0_fwdB", 8'(fwdBE), 8'(FWD_NONE));
      tick();

      // Load held in M for three not-ready cycles
      set_d(1, 9, 1, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_nop(); settle(); tick();
      dmem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         settle();
         chk("wait_stallM", 8'(stallM), 8'd1);
         chk("wait_flushW", 8'(flushW), 8'd1);
         tick();
      end
      dmem_ready = 1; settle();
      chk("wait_exit_state", 8'(hz_state), 8'(HZ_MEM_WAIT));
      chk("wait_exit_nostall", 8'(stallF), 8'd0);
      tick();
      settle();
      chk("wait_run", 8'(hz_state), 8'(HZ_RUN));
      chk("wait_no_timeout", 8'(mem_timeout), 8'd0);
      tick();

      // Redirect coincident with a load-use hazard
      set_d(1, 5, 1, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_d(1, 7, 5, 1, 1, 1, 1, 0, 0); redirectE = 1; settle();
      chk("rd_flushD", 8'(flushD), 8'd1);
      chk("rd_flushE", 8'(flushE), 8'd1);
      chk("rd_stallF", 8'(stallF), 8'd0);
      chk("rd_stallD", 8'(stallD), 8'd0);
      tick();
      redirectE = 0; set_nop(); settle(); tick();
      settle(); tick();

      // Six not-ready cycles with MAX_WAIT=4 -> sticky timeout
      set_d(1, 4, 2, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_nop(); settle(); tick();
      dmem_ready = 0;
      for (int i = 1; i <= 6; i++) begin
         settle();
         chk("to_rise", 8'(mem_timeout), 8'(i >= 5));
         tick();
      end
      dmem_ready = 1;
      for (int i = 0; i < 3; i++) begin
         set_d(1, 8, 1, 2, 1, 1, 1, 0, 0); settle();
         chk("to_sticky", 8'(mem_timeout), 8'd1);
         tick();
      end

      // Reset in the middle of a memory wait
      set_d(1, 3, 1, 0, 1, 0, 1, 1, 0); settle(); tick();
      set_d(1, 10, 3, 3, 1, 1, 1, 0, 0); settle(); tick();
      dmem_ready = 0; set_nop(); settle(); tick();
      settle(); tick();
      rst_n = 0; settle();
      chk("rst_mid_state", 8'(hz_state), 8'(HZ_RUN));
      chk("rst_mid_stallM", 8'(stallM), 8'd0);
      chk("rst_mid_timeout", 8'(mem_timeout), 8'd0);
      tick();
      redirectE = 1; settle();
      chk("rst_hold_flushD", 8'(flushD), 8'd0);
      tick();
      redirectE = 0; dmem_ready = 1; rst_n = 1;
      settle(); tick();

      // Random traffic on a small register set to provoke collisions
      for (int n = 0; n < 600; n++) begin
         set_d($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
               $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
         dmem_ready = $urandom_range(0, 3) != 0;
         redirectE  = $urandom_range(0, 7) == 0;
         settle();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Hazard and stall/flush controller for the rv32i 5-stage pipeline (F/D/E/M/W).
- Keeps a shadow scoreboard of E/M/W destination-register records and detects load-use hazards.
- Computes E-stage operand forwarding selects and freezes the pipeline while data memory is not ready.
- Sits beside the decode stage register: its stall/flush outputs gate the F/D, D/E, E/M and M/W pipeline registers.

Parameters:
- ADW, 5, register address width.
- MAX_WAIT, 16, dmem wait cycles before mem_timeout asserts (>=1).
- CW, $clog2(MAX_WAIT+1), wait counter width (derived; do not override).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_validD  in  1  D stage holds a real instruction.
- addr_1D  in  ADW  rs1 of D-stage instruction.
- addr_2D  in  ADW  rs2 of D-stage instruction.
- use_rs1D  in  1  D instruction reads rs1.
- use_rs2D  in  1  D instruction reads rs2.
- RdD  in  5  rd of D instruction.
- regwriteD  in  1  D instruction writes rd.
- resultsrcD  in  1  D instruction is a load.
- memwriteD  in  1  D instruction is a store.
- redirectE  in  1  E-stage control transfer; younger instructions are squashed.
- dmem_ready  in  1  data memory completes the M-stage access this cycle.
- stallF  out  1  hold PC.
- stallD  out  1  hold F/D register.
- stallE  out  1  hold D/E register.
- stallM  out  1  hold E/M register.
- flushD  out  1  bubble into F/D.
- flushE  out  1  bubble into D/E.
- flushW  out  1  bubble into M/W.
- fwdAE  out  fwd_sel_t  srcA forwarding select.
- fwdBE  out  fwd_sel_t  srcB forwarding select.
- hz_state  out  hz_state_t  FSM state.
- mem_timeout  out  1  sticky memory timeout error.

Behaviour:
- Reset (async, rst_n=0): state RUN, all scoreboard records invalid, wait_cnt=0, mem_timeout=0. All stall/flush outputs read 0 and fwdAE/fwdBE read FWD_NONE while reset is held.
- Scoreboard: records recE/recM/recW hold {valid, rd, regwrite, is_load, is_mem, rs1, rs2}.
  - Stage advance each clock unless frozen.
  - recE <= D info, or invalid when flushE/flushD-squashed.
  - recM <= recE.
  - recW <= recM, or invalid when flushW.
  - A record counts for hazards only if valid && regwrite && rd != 0. x0 is never a hazard source.
- Forwarding (combinational from recE/recM/recW):
  - fwdAE = FWD_MEM (2'b10) if recM matches recE.rs1 and recM is not a load.
  - Else FWD_WB (2'b01) if recW matches.
  - Else FWD_NONE (2'b00).
  - fwdBE uses the same rule on rs2.
- Load-use: recE is a load and matches (use_rs1D && addr_1D) or (use_rs2D && addr_2D), with instr_validD=1.
  - Response: stallF=stallD=1 and flushE=1 for exactly one cycle; no FSM state change.
- FSM:
  - RUN -> MEM_WAIT when recM.valid && recM.is_mem && !dmem_ready.
  - MEM_WAIT: stallF=stallD=stallE=stallM=1, flushW=1, wait_cnt increments (saturating at MAX_WAIT).
  - MEM_WAIT -> RUN on the cycle dmem_ready=1. That cycle is not stalled and wait_cnt clears.
  - A RUN cycle with the M access and dmem_ready=1 together costs no stall.
- mem_timeout sets when wait_cnt reaches MAX_WAIT. It stays set until reset; the FSM keeps waiting.
- Priority: MEM_WAIT freeze > redirectE > load-use.
  - redirectE in RUN: flushD=1 and flushE=1 in the same cycle. This overrides the load-use stall (stallF=stallD=0).
  - redirectE is ignored while frozen; the producer holds it until the freeze ends.
- Reset mid-MEM_WAIT: immediate return to reset values; any pending access is abandoned.
- All outputs are combinational from state/records/inputs; all state is registered.

Decomposition:
- rv32i_pkg additions:
  - fwd_sel_t enum {FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10}.
  - hz_state_t enum {HZ_RUN, HZ_MEM_WAIT}.
  - hz_rec_t packed struct for scoreboard records.
- One sub-module, hz_fwd_sel: pure combinational match of one source address against recM/recW, producing fwd_sel_t. Instantiated twice (A, B).

Test Plan:
- add x5,x1,x2 then add x6,x5,x3, dmem_ready=1 -> fwdAE=FWD_MEM in the cycle add x6 is in E. The following instruction reading x5 gets FWD_WB.
- lw x5,0(x1) then add x7,x5,x1 -> single cycle stallF=stallD=flushE=1. Then with add in E, fwdAE=FWD_WB; no further stall.
- lw x0,0(x1) then add x7,x0,x0 -> no stall, fwdAE=fwdBE=FWD_NONE.
- lw in M with dmem_ready low 3 cycles -> hz_state=MEM_WAIT and stallF..stallM=1, flushW=1 for 3 cycles. RUN on cycle 4; mem_timeout stays 0.
- MAX_WAIT=4, dmem_ready low 6 cycles -> mem_timeout rises on the cycle wait_cnt reaches 4 and stays 1 after ready and through later instructions.
- redirectE=1 coincident with a load-use hazard -> flushD=flushE=1, stallF=stallD=0.
- rst_n low mid-MEM_WAIT -> all outputs at reset values immediately, records invalid, hz_state=HZ_RUN.
